// File: rtl/sort_result_collector_if.sv
// Stream bundle around the sort result collector: the sorted word stream
// coming in from the systolic sorter and the replay handshake going out to
// the downstream consumer.
interface sort_result_collector_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] s_data;
  logic             s_active;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  // Collector side: consumes the sorter stream, drives the replay stream.
  modport master (
    input  s_data,
    input  s_active,
    input  m_ready,
    output m_data,
    output m_valid,
    output m_last
  );

  // Environment side: the sorter feeding words and the consumer draining them.
  modport slave (
    output s_data,
    output s_active,
    output m_ready,
    input  m_data,
    input  m_valid,
    input  m_last
  );
endinterface

// File: rtl/sort_result_collector.sv
// Reader end of the systolic sort datapath. Captures one frame of sorted
// words (up to SIZE) into a local memory while the sorter reports output
// activity, then replays the frame over a valid/ready handshake. Frames that
// are not non-decreasing raise order_err; words that cannot be stored
// (buffer full, or arriving while a frame is still draining) raise overflow.
module sort_result_collector #(
  parameter  int SIZE  = 1024,
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(SIZE + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sort_result_collector_if.master  bus,
  input  logic                     clear_err,
  output logic [CNT_W-1:0]         frame_len,
  output logic                     done,
  output logic                     busy,
  output logic                     order_err,
  output logic                     overflow
);

  localparam int               AW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Frame buffer and the last stored word used for the ordering check.
  logic [WIDTH-1:0] mem [SIZE];
  logic [WIDTH-1:0] prev;

  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] rd_ptr_nxt;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  // Per-cycle control strobes decoded from the state and the handshakes.
  logic first_wr;
  logic cap_wr;
  logic cap_drop;
  logic cap_exit;
  logic xfer_next;
  logic xfer_last;
  logic drain_drop;
  logic mem_we;
  logic order_set;
  logic ovf_set;

  // State register; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: a frame starts on the first active word, ends capture
  // on the first inactive cycle, and ends draining on transfer of the last word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.s_active) state_nxt = CAPTURE;
      CAPTURE: if (!bus.s_active) state_nxt = DRAIN;
      DRAIN:   if (bus.m_valid && bus.m_ready && bus.m_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/strobe decode: busy flag, memory write port and replay read address.
  always_comb begin
    busy       = 1'b0;
    first_wr   = 1'b0;
    cap_wr     = 1'b0;
    cap_drop   = 1'b0;
    cap_exit   = 1'b0;
    xfer_next  = 1'b0;
    xfer_last  = 1'b0;
    drain_drop = 1'b0;
    case (state)
      IDLE: begin
        first_wr = bus.s_active;
      end
      CAPTURE: begin
        busy     = 1'b1;
        cap_wr   = bus.s_active && (wr_ptr < SIZE_C);
        cap_drop = bus.s_active && (wr_ptr >= SIZE_C);
        cap_exit = !bus.s_active;
      end
      DRAIN: begin
        busy       = 1'b1;
        xfer_next  = bus.m_valid && bus.m_ready && !bus.m_last;
        xfer_last  = bus.m_valid && bus.m_ready && bus.m_last;
        drain_drop = bus.s_active;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    mem_we     = first_wr || cap_wr;
    wr_addr    = first_wr ? '0 : wr_ptr[AW-1:0];
    // On capture exit the first word is fetched; afterwards the word after
    // the one being transferred is prefetched so m_ready=1 streams bubble-free.
    rd_ptr_nxt = cap_exit ? '0 : (rd_ptr + ONE_C);
    rd_addr    = rd_ptr_nxt[AW-1:0];
    order_set  = cap_wr && (bus.s_data < prev);
    ovf_set    = cap_drop || drain_drop;
  end

  // Frame storage and predecessor word; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= bus.s_data;
      prev         <= bus.s_data;
    end
  end

  // Write/read pointers and the captured frame length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_len <= '0;
    end else begin
      if (first_wr) begin
        wr_ptr <= ONE_C;
      end else if (cap_wr) begin
        wr_ptr <= wr_ptr + ONE_C;
      end
      if (cap_exit || xfer_next) begin
        rd_ptr <= rd_ptr_nxt;
      end
      if (cap_exit) begin
        frame_len <= wr_ptr;
      end
    end
  end

  // Replay register: loads a new word only when one is consumed, so the
  // presented word holds steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_data  <= '0;
      bus.m_valid <= 1'b0;
      bus.m_last  <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= xfer_last;
      if (cap_exit) begin
        bus.m_data  <= mem[rd_addr];
        bus.m_valid <= 1'b1;
        bus.m_last  <= (wr_ptr == ONE_C);
      end else if (xfer_next) begin
        bus.m_data  <= mem[rd_addr];
        bus.m_last  <= (rd_ptr_nxt == (frame_len - ONE_C));
      end else if (xfer_last) begin
        bus.m_valid <= 1'b0;
        bus.m_last  <= 1'b0;
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as clear_err wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (order_set) begin
        order_err <= 1'b1;
      end else if (clear_err) begin
        order_err <= 1'b0;
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sort_result_collector.sv
// Directed bench for sort_result_collector at SIZE=4. A queue model holds
// the words each frame must replay; a negedge process checks every transfer,
// hold stability under backpressure, and the done pulse against it.
module tb_sort_result_collector;

  localparam int SIZE  = 4;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(SIZE + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear_err;
  logic [CNT_W-1:0] frame_len;
  logic             done;
  logic             busy;
  logic             order_err;
  logic             overflow;

  sort_result_collector_if #(.WIDTH(WIDTH)) bus ();

  sort_result_collector #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clear_err (clear_err),
    .frame_len (frame_len),
    .done      (done),
    .busy      (busy),
    .order_err (order_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    bit               last;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   exp_ord;
  bit   exp_ovf;
  int   exp_len;
  bit   exp_done_nxt;
  bit   hold_v;
  logic [WIDTH-1:0] hold_d;
  logic hold_l;
  logic [WIDTH-1:0] fw [8];
  int   fn;

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transfer scoreboard, hold-stability and done-pulse checks.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_done_nxt = 1'b0;
      hold_v       = 1'b0;
    end else begin
      chk_eq("done_pulse", {63'd0, done}, {63'd0, exp_done_nxt});
      exp_done_nxt = 1'b0;
      if (hold_v) begin
        chk_eq("hold_valid", {63'd0, bus.m_valid}, 64'd1);
        chk_eq("hold_data", {32'd0, bus.m_data}, {32'd0, hold_d});
        chk_eq("hold_last", {63'd0, bus.m_last}, {63'd0, hold_l});
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_word: got %0h expected no transfer", bus.m_data);
        end else begin
          cur = exp_q.pop_front();
          chk_eq("m_data", {32'd0, bus.m_data}, {32'd0, cur.data});
          chk_eq("m_last", {63'd0, bus.m_last}, {63'd0, cur.last});
          if (cur.last) exp_done_nxt = 1'b1;
        end
      end
      hold_v = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
      hold_d = bus.m_data;
      hold_l = bus.m_last;
    end
  end

  // Drive fw[0..fn-1] as one burst; the model keeps the first SIZE words.
  task automatic send_frame();
    int   n_cap;
    exp_t t;
    n_cap = (fn < SIZE) ? fn : SIZE;
    for (int i = 0; i < fn; i++) begin
      bus.s_active = 1'b1;
      bus.s_data   = fw[i];
      if (i < SIZE) begin
        t.data = fw[i];
        t.last = (i == n_cap - 1);
        exp_q.push_back(t);
        if (i > 0 && fw[i] < fw[i-1]) exp_ord = 1'b1;
      end else begin
        exp_ovf = 1'b1;
      end
      tick();
      chk_eq("order_err_capture", {63'd0, order_err}, {63'd0, exp_ord});
      chk_eq("overflow_capture", {63'd0, overflow}, {63'd0, exp_ovf});
    end
    bus.s_active = 1'b0;
    bus.s_data   = '0;
    exp_len      = n_cap;
    chk_eq("busy_capture", {63'd0, busy}, 64'd1);
    chk_eq("valid_before_drain", {63'd0, bus.m_valid}, 64'd0);
  endtask

  // Let the frame drain; optional backpressure pattern and an optional
  // two-word sorter burst arriving while draining.
  task automatic drain(input bit slow, input bit burst);
    bit seen;
    bit pat [5];
    seen   = 1'b0;
    pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b0; pat[4] = 1'b1;
    for (int n = 0; n < 80 && !seen; n++) begin
      bus.m_ready = slow ? pat[n % 5] : 1'b1;
      if (burst && (n == 1 || n == 2)) begin
        bus.s_active = 1'b1;
        bus.s_data   = 32'h99;
        exp_ovf      = 1'b1;
      end else begin
        bus.s_active = 1'b0;
      end
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    bus.s_active = 1'b0;
    bus.m_ready  = 1'b1;
    chk_eq("drain_done_seen", {63'd0, seen}, 64'd1);
    chk_eq("frame_len", {{(64-CNT_W){1'b0}}, frame_len}, 64'(exp_len));
    chk_eq("order_err_end", {63'd0, order_err}, {63'd0, exp_ord});
    chk_eq("overflow_end", {63'd0, overflow}, {63'd0, exp_ovf});
    chk_eq("busy_idle", {63'd0, busy}, 64'd0);
    chk_eq("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    exp_ord   = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_m_data"}, {32'd0, bus.m_data}, 64'd0);
    chk_eq({tag, "_m_valid"}, {63'd0, bus.m_valid}, 64'd0);
    chk_eq({tag, "_m_last"}, {63'd0, bus.m_last}, 64'd0);
    chk_eq({tag, "_frame_len"}, {{(64-CNT_W){1'b0}}, frame_len}, 64'd0);
    chk_eq({tag, "_done"}, {63'd0, done}, 64'd0);
    chk_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk_eq({tag, "_order_err"}, {63'd0, order_err}, 64'd0);
    chk_eq({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
  endtask

  initial begin
    rst_n        = 1'b1;
    clear_err    = 1'b0;
    bus.s_active = 1'b0;
    bus.s_data   = '0;
    bus.m_ready  = 1'b1;
    exp_ord      = 1'b0;
    exp_ovf      = 1'b0;
    exp_len      = 0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic replay 1,2,3,4
    fw[0] = 32'd1; fw[1] = 32'd2; fw[2] = 32'd3; fw[3] = 32'd4; fn = 4;
    send_frame();
    tick();
    chk_eq("basic_first_valid", {63'd0, bus.m_valid}, 64'd1);
    chk_eq("basic_first_data", {32'd0, bus.m_data}, 64'd1);
    chk_eq("basic_first_last", {63'd0, bus.m_last}, 64'd0);
    chk_eq("basic_frame_len", {{(64-CNT_W){1'b0}}, frame_len}, 64'd4);
    drain(1'b0, 1'b0);
    chk_eq("basic_order_err", {63'd0, order_err}, 64'd0);

    // Backpressure on the same frame
    send_frame();
    drain(1'b1, 1'b0);

    // Out-of-order frame 5,3,7 then clear
    fw[0] = 32'd5; fw[1] = 32'd3; fw[2] = 32'd7; fn = 3;
    send_frame();
    drain(1'b0, 1'b0);
    chk_eq("order_err_set", {63'd0, order_err}, 64'd1);
    pulse_clear();
    chk_eq("order_err_cleared", {63'd0, order_err}, 64'd0);

    // Overflow: 6 words into a 4-deep buffer, plus a burst while draining
    for (int i = 0; i < 6; i++) fw[i] = 32'(10 + i);
    fn = 6;
    send_frame();
    drain(1'b1, 1'b1);
    chk_eq("ovf_frame_len", {{(64-CNT_W){1'b0}}, frame_len}, 64'd4);
    chk_eq("ovf_flag", {63'd0, overflow}, 64'd1);
    pulse_clear();
    chk_eq("ovf_cleared", {63'd0, overflow}, 64'd0);

    // Burst during the drain of an in-range frame is dropped and flagged
    fw[0] = 32'd1; fw[1] = 32'd2; fw[2] = 32'd3; fn = 3;
    send_frame();
    drain(1'b1, 1'b1);
    chk_eq("drain_drop_ovf", {63'd0, overflow}, 64'd1);
    pulse_clear();

    // Reset after two of four words have been transferred
    fw[0] = 32'd21; fw[1] = 32'd22; fw[2] = 32'd23; fw[3] = 32'd24; fn = 4;
    bus.m_ready = 1'b1;
    send_frame();
    tick();
    tick();
    tick();
    chk_eq("mid_drain_word", {32'd0, bus.m_data}, 64'd23);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    exp_ord = 1'b0;
    exp_ovf = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    fw[0] = 32'd8; fw[1] = 32'd9; fn = 2;
    send_frame();
    drain(1'b0, 1'b0);
    chk_eq("post_reset_frame_len", {{(64-CNT_W){1'b0}}, frame_len}, 64'd2);

    // Single-word frame with the largest value
    fw[0] = 32'hFFFF_FFFF; fn = 1;
    send_frame();
    tick();
    chk_eq("single_valid", {63'd0, bus.m_valid}, 64'd1);
    chk_eq("single_last", {63'd0, bus.m_last}, 64'd1);
    chk_eq("single_data", {32'd0, bus.m_data}, 64'hFFFF_FFFF);
    drain(1'b0, 1'b0);
    chk_eq("single_frame_len", {{(64-CNT_W){1'b0}}, frame_len}, 64'd1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
